n64_command_transmitter: RTL and testbench

Drives the host-to-controller half of the N64 single-wire protocol: it serialises one command byte (e.g. 0x01 poll, 0x00 info, 0xFF reset) plus a stop bit onto the open-drain data line. It then hands the line to the controller-response reader by raising `rx_enable`. It sits between the fabric/MSS command logic and the bidirectional GPIO pad, alongside the reader that decodes the controller's 32-bit reply.

---
 rtl/n64_command_transmitter.sv | 149 ++++++++++++++
 tb/tb_n64_command_transmitter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/n64_command_transmitter.sv
// Host-to-controller half of the N64 single-wire protocol: waits for a guard
// interval of idle-high line, sends one MSB-first command byte plus stop bit, then enables the reader.
module n64_command_transmitter #(
   parameter int US_CYCLES = 100,
   parameter int GUARD_US  = 8
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       start,
   input  logic [7:0] cmd_byte,
   input  logic       line_in,
   output logic       line_oe,
   output logic       busy,
   output logic       done,
   output logic       rx_enable
);

   localparam int GUARD_N = GUARD_US * US_CYCLES;
   localparam int PH_W    = $clog2(3 * US_CYCLES + 1);
   localparam int G_W     = $clog2(GUARD_N + 1);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] GUARD    = 3'd1;
   localparam logic [2:0] BIT_LOW  = 3'd2;
   localparam logic [2:0] BIT_HIGH = 3'd3;
   localparam logic [2:0] STOP_LOW = 3'd4;

   localparam logic [PH_W-1:0] SHORT_LAST = PH_W'(US_CYCLES - 1);
   localparam logic [PH_W-1:0] LONG_LAST  = PH_W'(3 * US_CYCLES - 1);
   localparam logic [G_W-1:0]  GUARD_LAST = G_W'(GUARD_N - 1);
   localparam logic [G_W-1:0]  GUARD_FULL = G_W'(GUARD_N);

   logic [2:0]      state;
   logic [7:0]      cmd_reg;
   logic [2:0]      bit_idx;
   logic [PH_W-1:0] phase;
   logic [G_W-1:0]  guard_cnt;
   logic            line_meta;
   logic            line_sync;
   logic            cur_bit;
   logic [PH_W-1:0] low_last;
   logic [PH_W-1:0] high_last;

   // A 0 bit is 3 us low / 1 us high, a 1 bit is 1 us low / 3 us high.
   assign cur_bit   = cmd_reg[bit_idx];
   assign low_last  = cur_bit ? SHORT_LAST : LONG_LAST;
   assign high_last = cur_bit ? LONG_LAST  : SHORT_LAST;

   // NOTE: the synchroniser resets to 0 so the line must be proven idle after
   // reset before the guard count can advance.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         line_meta <= 1'b0;
         line_sync <= 1'b0;
      end else begin
         line_meta <= line_in;
         line_sync <= line_meta;
      end
   end

   // NOTE: all state here uses non-blocking assignments so every branch sees
   // the pre-edge values of phase, bit_idx and guard_cnt.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         cmd_reg   <= 8'h00;
         bit_idx   <= 3'd0;
         phase     <= '0;
         guard_cnt <= '0;
         line_oe   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rx_enable <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cmd_reg   <= cmd_byte;
                  bit_idx   <= 3'd7;
                  rx_enable <= 1'b0;
                  busy      <= 1'b1;
                  guard_cnt <= '0;
                  phase     <= '0;
                  state     <= GUARD;
               end
            end

            GUARD: begin
               if (!line_sync) begin
                  guard_cnt <= '0;
               end else if (guard_cnt >= GUARD_LAST) begin
                  guard_cnt <= GUARD_FULL;
                  phase     <= '0;
                  line_oe   <= 1'b1;
                  state     <= BIT_LOW;
               end else begin
                  guard_cnt <= guard_cnt + G_W'(1);
               end
            end

            BIT_LOW: begin
               if (phase == low_last) begin
                  phase   <= '0;
                  line_oe <= 1'b0;
                  state   <= BIT_HIGH;
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end

            BIT_HIGH: begin
               if (phase == high_last) begin
                  phase   <= '0;
                  line_oe <= 1'b1;
                  if (bit_idx != 3'd0) begin
                     bit_idx <= bit_idx - 3'd1;
                     state   <= BIT_LOW;
                  end else begin
                     state <= STOP_LOW;
                  end
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end

            STOP_LOW: begin
               if (phase == SHORT_LAST) begin
                  phase     <= '0;
                  line_oe   <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  rx_enable <= 1'b1;
                  state     <= IDLE;
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end

            default: begin
               line_oe <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_n64_command_transmitter.sv
// Self-checking bench for n64_command_transmitter: line_oe run lengths, guard timing,
// done/rx_enable handshake and async reset, against a bit-cell reference model.
module tb_n64_command_transmitter;

   localparam int US       = 4;
   localparam int GUARD_US = 8;
   localparam int N        = US * GUARD_US;

   logic       clock    = 1'b0;
   logic       resetn   = 1'b0;
   logic       start    = 1'b0;
   logic [7:0] cmd_byte = 8'h00;
   logic       line_in  = 1'b1;
   logic       line_oe;
   logic       busy;
   logic       done;
   logic       rx_enable;

   int cyc      = 0;
   int pass_cnt = 0;
   int chk_cnt  = 0;
   int exp_runs[$];

   n64_command_transmitter #(.US_CYCLES(US), .GUARD_US(GUARD_US)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .start     (start),
      .cmd_byte  (cmd_byte),
      .line_in   (line_in),
      .line_oe   (line_oe),
      .busy      (busy),
      .done      (done),
      .rx_enable (rx_enable)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   // Expected line_oe run lengths from the first pull-low to the done edge.
   function automatic void build_model(input logic [7:0] b);
      exp_runs.delete();
      for (int i = 7; i >= 0; i--) begin
         if (b[i]) begin exp_runs.push_back(US);     exp_runs.push_back(3 * US); end
         else      begin exp_runs.push_back(3 * US); exp_runs.push_back(US);     end
      end
      exp_runs.push_back(US);
   endfunction

   task automatic accept(input logic [7:0] b, output int k);
      @(negedge clock);
      start    = 1'b1;
      cmd_byte = b;
      @(posedge clock);
      #1;
      k        = cyc;
      start    = 1'b0;
      cmd_byte = 8'($urandom);
      @(negedge clock);
      check("busy_on_accept", busy, 1);
      check("rx_en_on_accept", rx_enable, 0);
      check("oe_on_accept", line_oe, 0);
   endtask

   // Returns at the sample one cycle after done; dn is the done edge.
   task automatic watch_frame(input logic [7:0] b, input int exp_rise, input bit junk, output int dn);
      int  rise = -1;
      int  ndone = 0;
      int  len = 0;
      bit  q[$];
      int  runs[$];
      logic dn_busy = 1'bx, dn_rx = 1'bx, dn_oe = 1'bx, post_done = 1'b1;
      dn = -1;
      build_model(b);
      for (int n = 0; n < 600; n++) begin
         @(negedge clock);
         if (junk) begin
            if (n == 50) begin start = 1'b1; cmd_byte = ~b; end
            if (n == 51) start = 1'b0;
         end
         if (done) ndone++;
         if (dn >= 0) begin post_done = done; break; end
         if (rise < 0 && line_oe) rise = cyc;
         if (rise >= 0) begin
            if (done) begin
               dn = cyc; dn_busy = busy; dn_rx = rx_enable; dn_oe = line_oe;
            end else begin
               q.push_back(line_oe);
            end
         end
      end
      foreach (q[i]) begin
         len++;
         if (i == q.size() - 1 || q[i+1] != q[i]) begin runs.push_back(len); len = 0; end
      end
      check("rise_edge", rise, exp_rise);
      check("done_edge", dn, rise + 33 * US);
      check("run_count", runs.size(), exp_runs.size());
      for (int i = 0; i < runs.size() && i < exp_runs.size(); i++)
         check($sformatf("run%0d_byte%02h", i, b), runs[i], exp_runs[i]);
      check("done_count", ndone, 1);
      check("done_width", post_done, 0);
      check("busy_at_done", dn_busy, 0);
      check("rx_en_at_done", dn_rx, 1);
      check("oe_at_done", dn_oe, 0);
   endtask

   task automatic send(input logic [7:0] b, input bit junk);
      int k, dn;
      accept(b, k);
      watch_frame(b, k + N, junk, dn);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
      $fatal(1);
   end

   initial begin
      int k, m, g, dn, cnt_oe, cnt_nb, ndone;
      logic [7:0] rb;

      // Reset held, then released with start low.
      repeat (3) @(negedge clock);
      check("rst_oe", line_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rx_en", rx_enable, 0);
      resetn = 1'b1;
      cnt_oe = 0;
      repeat (10) begin
         @(negedge clock);
         cnt_oe += int'(line_oe) + int'(busy) + int'(done) + int'(rx_enable);
      end
      check("post_rst_quiet", cnt_oe, 0);

      // Poll, then reset command with a mid-frame start that must be ignored.
      send(8'h01, 1'b0);
      send(8'hFF, 1'b1);
      check("rx_en_held_idle", rx_enable, 1);

      // Guard with the line held low, then released.
      line_in = 1'b0;
      repeat (5) @(negedge clock);
      accept(8'h01, k);
      cnt_oe = 0; cnt_nb = 0;
      repeat (60) begin
         @(negedge clock);
         if (line_oe) cnt_oe++;
         if (!busy) cnt_nb++;
      end
      check("guard_low_oe", cnt_oe, 0);
      check("guard_low_busy", cnt_nb, 0);
      @(posedge clock); #1; line_in = 1'b1; m = cyc;
      watch_frame(8'h01, m + N + 2, 1'b0, dn);

      // Guard restarted by a one-cycle low glitch.
      line_in = 1'b0;
      repeat (5) @(negedge clock);
      accept(8'hA5, k);
      repeat (10) @(negedge clock);
      @(posedge clock); #1; line_in = 1'b1;
      repeat (10) @(posedge clock);
      #1; line_in = 1'b0;
      @(posedge clock); #1; line_in = 1'b1; g = cyc;
      watch_frame(8'hA5, g + N + 2, 1'b0, dn);

      // Async reset in the low phase of bit 3 of 0x00.
      repeat (5) @(negedge clock);
      accept(8'h00, k);
      while (cyc < k + N + 66) @(negedge clock);
      check("oe_before_reset", line_oe, 1);
      #2 resetn = 1'b0;
      #1;
      check("async_rst_oe", line_oe, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_rx_en", rx_enable, 0);
      ndone = 0;
      repeat (3) begin @(negedge clock); if (done) ndone++; end
      resetn = 1'b1;
      repeat (100) begin @(negedge clock); if (done) ndone++; end
      check("no_done_after_reset", ndone, 0);
      send(8'h00, 1'b0);

      // Back-to-back with start held high throughout.
      @(negedge clock);
      start = 1'b1; cmd_byte = 8'h3C;
      @(posedge clock); #1; k = cyc; cmd_byte = 8'hC3;
      watch_frame(8'h3C, k + N, 1'b0, dn);
      check("b2b_accept_busy", busy, 1);
      check("b2b_rx_en_fall", rx_enable, 0);
      start = 1'b0;
      watch_frame(8'hC3, dn + 1 + N, 1'b0, dn);

      // Randomized bytes, gaps and mid-frame start pulses.
      for (int r = 0; r < 5; r++) begin
         rb = 8'($urandom);
         repeat ($urandom_range(0, 20)) @(negedge clock);
         send(rb, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
